// File: rtl/hazard_pkg.sv
// Shared encodings and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    FREEZE   = 2'd2
  } state_t;

  // Legal range of the per-branch flush length and the width of its down-counter.
  localparam int FLUSH_MIN = 1;
  localparam int FLUSH_MAX = 7;
  localparam int FCNT_W    = 3;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  localparam logic [4:0] X0_REG = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Latency: count updates on the edge following an inc.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, reset (async active-low), inc, count[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch squash, dmem freeze.
// Latency: control outputs are combinational (same cycle); state/counters update on clk.
// Backpressure: dmem_busy freezes everything and has priority over branch and load-use.
// Ports: IFID*/IDEX* hazard operands, branch_taken, dmem_busy in; PCWrite, IFIDWrite,
//        IFID_flush, IDEX_flush, freeze, stall_count, flush_count, state out.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFIDrs1,
  input  logic [4:0]       IFIDrs2,
  input  logic             IFIDuses_rs2,
  input  logic [4:0]       IDEXrd,
  input  logic             IDEXMemRead,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_CYCLES - 1);

  state_t            st, saved_st, eff_st;
  logic [FCNT_W-1:0] fcnt, saved_fcnt, eff_fcnt;
  logic              lu;
  logic              stall_inc, flush_inc;

  assign state = st;

  assign lu = IDEXMemRead && (IDEXrd != X0_REG) &&
              ((IDEXrd == IFIDrs1) || (IFIDuses_rs2 && (IDEXrd == IFIDrs2)));

  // Leaving FREEZE behaves as if the saved context were already live this cycle,
  // so a branch held in EX across the freeze is acted on when busy drops.
  always_comb begin
    eff_st   = st;
    eff_fcnt = fcnt;
    if (st == FREEZE) begin
      eff_st   = saved_st;
      eff_fcnt = saved_fcnt;
    end
  end

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    freeze     = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (!reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (dmem_busy) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      freeze    = 1'b1;
    end else begin
      case (eff_st)
        BR_FLUSH: begin
          // EX holds a bubble here, so branch_taken and lu are meaningless.
          IFID_flush = 1'b1;
          IDEX_flush = 1'b1;
        end
        RUN: begin
          if (branch_taken) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (lu) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEX_flush = 1'b1;
            stall_inc  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= RUN;
      fcnt       <= '0;
      saved_st   <= RUN;
      saved_fcnt <= '0;
    end else if (dmem_busy) begin
      if (st != FREEZE) begin
        saved_st   <= (st == BR_FLUSH) ? BR_FLUSH : RUN;
        saved_fcnt <= fcnt;
        st         <= FREEZE;
      end
    end else begin
      case (eff_st)
        RUN: begin
          if (branch_taken && (FLUSH_CYCLES > 1)) begin
            st   <= BR_FLUSH;
            fcnt <= FLUSH_INIT;
          end else begin
            st   <= RUN;
            fcnt <= eff_fcnt;
          end
        end
        BR_FLUSH: begin
          if (eff_fcnt <= FCNT_W'(1)) begin
            st   <= RUN;
            fcnt <= '0;
          end else begin
            st   <= BR_FLUSH;
            fcnt <= eff_fcnt - FCNT_W'(1);
          end
        end
        default: begin
          st   <= RUN;
          fcnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (1-cycle flush / 16-bit counters and
// 3-cycle flush / 2-bit counters) share stimulus; a cycle-level reference model pushes
// expected outputs and a monitor pops and compares just before each rising edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IFIDrs1, IFIDrs2, IDEXrd;
  logic       IFIDuses_rs2, IDEXMemRead, branch_taken, dmem_busy;

  logic        pcw_a, ifw_a, iff_a, idf_a, frz_a;
  logic [15:0] stall_a, flush_a;
  logic [1:0]  state_a;
  logic        pcw_b, ifw_b, iff_b, idf_b, frz_b;
  logic [1:0]  stall_b, flush_b;
  logic [1:0]  state_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2),
    .IFIDuses_rs2(IFIDuses_rs2), .IDEXrd(IDEXrd), .IDEXMemRead(IDEXMemRead),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .PCWrite(pcw_a), .IFIDWrite(ifw_a), .IFID_flush(iff_a), .IDEX_flush(idf_a),
    .freeze(frz_a), .stall_count(stall_a), .flush_count(flush_a), .state(state_a)
  );

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2),
    .IFIDuses_rs2(IFIDuses_rs2), .IDEXrd(IDEXrd), .IDEXMemRead(IDEXMemRead),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .PCWrite(pcw_b), .IFIDWrite(ifw_b), .IFID_flush(iff_b), .IDEX_flush(idf_b),
    .freeze(frz_b), .stall_count(stall_b), .flush_count(flush_b), .state(state_b)
  );

  // Expected vector: {PCWrite, IFIDWrite, IFID_flush, IDEX_flush, freeze, state, stall, flush}
  logic [38:0] q_a[$];
  logic [38:0] q_b[$];

  int tests = 0;
  int fails = 0;

  // Reference model: remaining flush cycles, whether last cycle was frozen, event totals.
  int fc[2]   = '{1, 3};
  int cmax[2] = '{65535, 3};
  int fl_left[2];
  bit frozen[2];
  int n_stall[2];
  int n_flush[2];

  task automatic model_step(input int i);
    logic [4:0]  o;
    logic [38:0] e;
    int          es;
    bit          hz;
    hz = IDEXMemRead && (IDEXrd != 0) &&
         ((IDEXrd == IFIDrs1) || (IFIDuses_rs2 && (IDEXrd == IFIDrs2)));
    if (!reset) begin
      e = {5'b00110, 2'd0, 16'd0, 16'd0};
      fl_left[i] = 0; frozen[i] = 0; n_stall[i] = 0; n_flush[i] = 0;
    end else begin
      es = frozen[i] ? 2 : ((fl_left[i] > 0) ? 1 : 0);
      e[31:0] = {16'(n_stall[i]), 16'(n_flush[i])};
      if (dmem_busy) begin
        o = 5'b00001;
        frozen[i] = 1;
      end else begin
        frozen[i] = 0;
        if (fl_left[i] > 0) begin
          o = 5'b11110;
          fl_left[i]--;
        end else if (branch_taken) begin
          o = 5'b11110;
          if (n_flush[i] < cmax[i]) n_flush[i]++;
          fl_left[i] = fc[i] - 1;
        end else if (hz) begin
          o = 5'b00010;
          if (n_stall[i] < cmax[i]) n_stall[i]++;
        end else begin
          o = 5'b11000;
        end
      end
      e = {o, 2'(es), e[31:0]};
    end
    if (i == 0) q_a.push_back(e); else q_b.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic busy, input logic br, input logic mr,
                     input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u2);
    @(negedge clk);
    reset = rst; dmem_busy = busy; branch_taken = br; IDEXMemRead = mr;
    IDEXrd = rd; IFIDrs1 = r1; IFIDrs2 = r2; IFIDuses_rs2 = u2;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
  endtask

  task automatic compare(input string name, input logic [38:0] act, input logic [38:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got o=%b st=%0d stall=%0d flush=%0d expected o=%b st=%0d stall=%0d flush=%0d",
               name, $time, act[38:34], act[33:32], act[31:16], act[15:0],
               exp[38:34], exp[33:32], exp[31:16], exp[15:0]);
    end
  endtask

  // Monitor: outputs are valid every cycle; sample 2 ns after the input-drive edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q_a.size() > 0)
        compare("cfg_a", {pcw_a, ifw_a, iff_a, idf_a, frz_a, state_a, stall_a, flush_a},
                q_a.pop_front());
      if (q_b.size() > 0)
        compare("cfg_b", {pcw_b, ifw_b, iff_b, idf_b, frz_b, state_b, 14'd0, stall_b, 14'd0, flush_b},
                q_b.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dmem_busy = 0; branch_taken = 0; IDEXMemRead = 0;
    IDEXrd = 0; IFIDrs1 = 0; IFIDrs2 = 0; IFIDuses_rs2 = 0;
    #1 reset = 1'b0;
    cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);   // inputs ignored under reset
    idle(2);

    // Load-use on rs1, then the bubble
    cyc(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    idle(2);
    // x0 and rs2 gating
    cyc(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    cyc(1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0);
    cyc(1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1);
    idle(1);
    // Branch coincident with load-use
    cyc(1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
    idle(4);
    // Plain branch
    cyc(1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0);
    idle(4);
    // Freeze starting on the second flush cycle
    cyc(1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0);
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    idle(4);
    // Branch held in EX across a freeze from RUN
    cyc(1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0);
    cyc(1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0);
    cyc(1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0);
    idle(4);
    // Five stalls to saturate the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0);
      idle(1);
    end
    // Reset asserted mid-flush
    cyc(1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0);
    cyc(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    idle(2);

    // Randomized traffic with small register indices to provoke hazards
    for (int k = 0; k < 2000; k++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle(2);

    @(negedge clk);
    #3;
    tests++;
    if ((q_a.size() != 0) || (q_b.size() != 0)) begin
      fails++;
      $display("FAIL drain got %0d/%0d entries left expected 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
